kgp_risc_run_controller: RTL and testbench

KGP_RISC_RUN_CONTROLLER -- requirements
Module: kgp_risc_run_controller

---
 rtl/kgp_risc_pkg.sv | 10 +
 rtl/kgp_clk_en_div.sv | 28 ++
 rtl/kgp_risc_run_controller.sv | 102 ++++++++++
 tb/tb_kgp_risc_run_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg: shared FSM encoding and parameter defaults for the KGP-RISC run controller
package kgp_risc_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;
  localparam int DIV_DEF         = 20;
  localparam int RST_CYCLES_DEF  = 2;
  localparam int HALT_CYCLES_DEF = 4;
  localparam int MAX_CYCLES_DEF  = 65535;
  localparam int PC_W_DEF        = 32;
  localparam int CNT_W_DEF       = 32;
endpackage

// File: rtl/kgp_clk_en_div.sv
// kgp_clk_en_div: free-running divider producing a registered one-cycle enable every DIV cycles
module kgp_clk_en_div #(
  parameter int DIV = 20
) (
  input  logic f_clka,
  input  logic reset,
  output logic clka_en
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt_q, cnt_d;
  logic         en_q, en_d;
  // wrap at DIV-1; the enable is precomputed so it is high exactly while the counter sits at DIV-1
  always_comb begin
    cnt_d = (cnt_q == W'(DIV - 1)) ? '0 : cnt_q + W'(1);
    en_d  = cnt_d == W'(DIV - 1);
  end
  // counter and enable registers
  always_ff @(posedge f_clka) begin
    if (reset) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end
  assign clka_en = en_q;
endmodule

// File: rtl/kgp_risc_run_controller.sv
// kgp_risc_run_controller: sequences processor reset, run, halt detection and cycle-limit timeout
module kgp_risc_run_controller
  import kgp_risc_pkg::*;
#(
  parameter int DIV         = DIV_DEF,
  parameter int RST_CYCLES  = RST_CYCLES_DEF,
  parameter int HALT_CYCLES = HALT_CYCLES_DEF,
  parameter int MAX_CYCLES  = MAX_CYCLES_DEF,
  parameter int PC_W        = PC_W_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             f_clka,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc_in,
  output logic             clka_en,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count,
  output logic [PC_W-1:0]  last_pc
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [PC_W-1:0]  lpc_q, lpc_d;
  logic [7:0]       stab_q, stab_d;
  logic [31:0]      pcnt_q, pcnt_d;
  logic             tmo_q, tmo_d;
  logic             cpu_reset_q, running_q, done_q;

  kgp_clk_en_div #(.DIV(DIV)) u_div (
    .f_clka (f_clka),
    .reset  (reset),
    .clka_en(clka_en)
  );

  // next state: pulse counter is shared between RESET hold length and RUN cycle limit
  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    lpc_d   = lpc_q;
    stab_d  = stab_q;
    pcnt_d  = pcnt_q;
    tmo_d   = tmo_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
      state_d = S_RESET;
      icnt_d  = '0;
      lpc_d   = '0;
      stab_d  = '0;
      pcnt_d  = '0;
      tmo_d   = 1'b0;
    end else if (clka_en && state_q == S_RESET) begin
      pcnt_d = pcnt_q + 32'd1;
      if (pcnt_d == 32'(RST_CYCLES)) begin
        state_d = S_RUN;
        pcnt_d  = '0;
      end
    end else if (clka_en && state_q == S_RUN) begin
      pcnt_d = pcnt_q + 32'd1;
      icnt_d = &icnt_q ? icnt_q : icnt_q + CNT_W'(1);
      lpc_d  = pc_in;
      stab_d = (pcnt_q != '0 && pc_in == lpc_q) ? stab_q + 8'd1 : '0;
      if (stab_d == 8'(HALT_CYCLES - 1) || pcnt_d == 32'(MAX_CYCLES)) begin
        state_d = S_DONE;
        tmo_d   = stab_d != 8'(HALT_CYCLES - 1);
      end
    end
  end

  // state and registered outputs; processor stays in reset while idle or resetting
  always_ff @(posedge f_clka) begin
    if (reset) begin
      state_q     <= S_IDLE;
      icnt_q      <= '0;
      lpc_q       <= '0;
      stab_q      <= '0;
      pcnt_q      <= '0;
      tmo_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      icnt_q      <= icnt_d;
      lpc_q       <= lpc_d;
      stab_q      <= stab_d;
      pcnt_q      <= pcnt_d;
      tmo_q       <= tmo_d;
      cpu_reset_q <= state_d == S_IDLE || state_d == S_RESET;
      running_q   <= state_d == S_RUN;
      done_q      <= state_d == S_DONE;
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = tmo_q;
  assign instr_count = icnt_q;
  assign last_pc     = lpc_q;
endmodule

// File: tb/tb_kgp_risc_run_controller.sv
// tb_kgp_risc_run_controller: directed checks of reset, divider timing, halt, timeout and abort
module tb_kgp_risc_run_controller;
  logic        clk = 1'b0;
  logic        reset_a, start_a, rst_bc, start_bc;
  logic [31:0] pc_a, pc_bc;
  logic        en_a, cr_a, run_a, done_a, tmo_a;
  logic [31:0] ic_a, lpc_a;
  logic        en_b, cr_b, run_b, done_b, tmo_b;
  logic [31:0] ic_b, lpc_b;
  logic        en_c, cr_c, run_c, done_c, tmo_c;
  logic [31:0] ic_c, lpc_c;
  int tests = 0;
  int failed = 0;
  int halt_pc [7] = '{0, 4, 8, 12, 12, 12, 12};

  always #5 clk = ~clk;

  kgp_risc_run_controller #(.DIV(4), .RST_CYCLES(2), .HALT_CYCLES(4), .MAX_CYCLES(10)) dut_a (
    .f_clka(clk), .reset(reset_a), .start(start_a), .pc_in(pc_a), .clka_en(en_a), .cpu_reset(cr_a),
    .running(run_a), .done(done_a), .timeout(tmo_a), .instr_count(ic_a), .last_pc(lpc_a));
  kgp_risc_run_controller #(.DIV(4), .RST_CYCLES(2), .HALT_CYCLES(2), .MAX_CYCLES(4)) dut_b (
    .f_clka(clk), .reset(rst_bc), .start(start_bc), .pc_in(pc_bc), .clka_en(en_b), .cpu_reset(cr_b),
    .running(run_b), .done(done_b), .timeout(tmo_b), .instr_count(ic_b), .last_pc(lpc_b));
  kgp_risc_run_controller #(.DIV(4), .RST_CYCLES(2), .HALT_CYCLES(2), .MAX_CYCLES(2)) dut_c (
    .f_clka(clk), .reset(rst_bc), .start(start_bc), .pc_in(pc_bc), .clka_en(en_c), .cpu_reset(cr_c),
    .running(run_c), .done(done_c), .timeout(tmo_c), .instr_count(ic_c), .last_pc(lpc_c));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input int which);
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!(which != 0 ? en_b : en_a) && n < 20);
    chk("en_wait", which != 0 ? en_b : en_a, 1);
  endtask

  task automatic wait_run_a();
    int n = 0;
    while (!run_a && n < 40) begin
      step(1);
      n++;
    end
    chk("run_entry", run_a, 1);
  endtask

  task automatic halt_pulses();
    for (int k = 0; k < 7; k++) begin
      wait_en(0);
      pc_a = halt_pc[k];
      step(1);
      pc_a = 32'hdead_beef;
      if (k == 3) chk("halt_mid_count", ic_a, 4);
    end
  endtask

  task automatic check_halt(input string tag);
    chk({tag, "_done"}, done_a, 1);
    chk({tag, "_timeout"}, tmo_a, 0);
    chk({tag, "_last_pc"}, lpc_a, 12);
    chk({tag, "_count"}, ic_a, 7);
    chk({tag, "_running"}, run_a, 0);
  endtask

  task automatic restart_a();
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    chk("restart_done", done_a, 0);
    chk("restart_cpu_reset", cr_a, 1);
    chk("restart_count", ic_a, 0);
    chk("restart_timeout", tmo_a, 0);
    wait_run_a();
  endtask

  initial begin
    bit seen_done;
    reset_a = 1'b1; start_a = 1'b0; pc_a = '0;
    rst_bc = 1'b1; start_bc = 1'b0; pc_bc = '0;
    step(2);
    chk("rst_clka_en", en_a, 0);
    chk("rst_cpu_reset", cr_a, 1);
    chk("rst_running", run_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_timeout", tmo_a, 0);
    chk("rst_count", ic_a, 0);
    chk("rst_last_pc", lpc_a, 0);
    reset_a = 1'b0; start_a = 1'b1; rst_bc = 1'b0;
    step(1);
    start_a = 1'b0;
    chk("c1_en", en_a, 0);
    chk("c1_cpu_reset", cr_a, 1);
    chk("c1_running", run_a, 0);
    step(2);
    chk("c3_en", en_a, 1);
    step(1);
    chk("c4_en", en_a, 0);
    step(3);
    chk("c7_en", en_a, 1);
    chk("c7_cpu_reset", cr_a, 1);
    step(1);
    chk("c8_cpu_reset", cr_a, 0);
    chk("c8_running", run_a, 1);
    halt_pulses();
    check_halt("halt1");
    pc_a = 32'h55;
    step(10);
    chk("hold_done", done_a, 1);
    chk("hold_count", ic_a, 7);
    chk("hold_last_pc", lpc_a, 12);
    restart_a();
    for (int k = 0; k < 10; k++) begin
      wait_en(0);
      if (k == 9) begin
        chk("tmo_pre_done", done_a, 0);
        chk("tmo_pre_count", ic_a, 9);
      end
      pc_a = 100 + 4 * k;
    end
    step(1);
    chk("tmo_done", done_a, 1);
    chk("tmo_timeout", tmo_a, 1);
    chk("tmo_count", ic_a, 10);
    chk("tmo_last_pc", lpc_a, 136);
    restart_a();
    halt_pulses();
    check_halt("halt2");
    restart_a();
    start_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_en(0);
      pc_a = 200 + k;
    end
    step(1);
    chk("abort_pre_count", ic_a, 5);
    chk("abort_pre_running", run_a, 1);
    reset_a = 1'b1;
    step(1);
    reset_a = 1'b0;
    start_a = 1'b0;
    chk("abort_cpu_reset", cr_a, 1);
    chk("abort_count", ic_a, 0);
    chk("abort_running", run_a, 0);
    chk("abort_done", done_a, 0);
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      seen_done |= done_a;
    end
    chk("abort_no_done", seen_done, 0);
    start_bc = 1'b1;
    step(1);
    start_bc = 1'b0;
    for (int k = 0; k < 3; k++) wait_en(1);
    step(1);
    chk("b_first_count", ic_b, 1);
    chk("b_first_done", done_b, 0);
    wait_en(1);
    step(1);
    chk("b_done", done_b, 1);
    chk("b_timeout", tmo_b, 0);
    chk("b_count", ic_b, 2);
    chk("c_done", done_c, 1);
    chk("c_timeout", tmo_c, 0);
    chk("c_count", ic_c, 2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
